// File: rtl/mem_swap_ctrl.sv
// mem_swap_ctrl
// Exchanges the contents of two register-file locations through the
// file's single combinational read port and single synchronous write port.
// Each accepted request runs read A, read B, write A, write B, done.
// A same-address request skips both writes.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start             swap request, accepted only while idle
//   addr_a, addr_b    the two locations, captured with start
//   data_r            register-file read data (combinational from address_r)
//   address_r         register-file read address
//   address_w, we,
//   data_w            register-file write port
//   busy              swap in progress (read and write phases)
//   done              one-cycle pulse when a swap completes
//   swap_count        completed swaps, saturating at all-ones
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for start
// RD_A  | read location A into tmp_a
// RD_B  | read location B into tmp_b
// WR_A  | write tmp_b to location A
// WR_B  | write tmp_a to location B
// DONE  | pulse done, bump swap_count

module mem_swap_ctrl #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  addr_a,
  input  logic [ADDR_W-1:0]  addr_b,
  input  logic [DATA_W-1:0]  data_r,
  output logic [ADDR_W-1:0]  address_r,
  output logic [ADDR_W-1:0]  address_w,
  output logic               we,
  output logic [DATA_W-1:0]  data_w,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] swap_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_WR_A = 3'd3,
    S_WR_B = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] ra, rb;
  logic [DATA_W-1:0] tmp_a, tmp_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RD_A;
      S_RD_A:  state_nx = S_RD_B;
      S_RD_B:  state_nx = (ra == rb) ? S_DONE : S_WR_A;
      S_WR_A:  state_nx = S_WR_B;
      S_WR_B:  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra         <= '0;
      rb         <= '0;
      tmp_a      <= '0;
      tmp_b      <= '0;
      swap_count <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        ra <= addr_a;
        rb <= addr_b;
      end
      if (state == S_RD_A) tmp_a <= data_r;
      if (state == S_RD_B) tmp_b <= data_r;
      if (state == S_DONE && swap_count != '1) begin
        swap_count <= swap_count + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    address_r = ra;
    address_w = '0;
    data_w    = '0;
    we        = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_RD_A: busy = 1'b1;
      S_RD_B: begin
        busy      = 1'b1;
        address_r = rb;
      end
      S_WR_A: begin
        busy      = 1'b1;
        we        = 1'b1;
        address_w = ra;
        data_w    = tmp_b;
      end
      S_WR_B: begin
        busy      = 1'b1;
        we        = 1'b1;
        address_w = rb;
        data_w    = tmp_a;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    // A reset asserted during a write cycle must stop that write from
    // committing on the same edge that returns the FSM to idle.
    if (rst) we = 1'b0;
  end

endmodule

// File: tb/tb_mem_swap_ctrl.sv
module tb_mem_swap_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] addr_a, addr_b;

  logic [7:0]  data_r, data_w;
  logic [6:0]  address_r, address_w;
  logic        we, busy, done;
  logic [15:0] swap_count;

  logic [7:0] s_data_r, s_data_w;
  logic [6:0] s_address_r, s_address_w;
  logic       s_we, s_busy, s_done;
  logic [1:0] s_swap_count;

  logic       pre_we;
  logic [6:0] pre_addr;
  logic [7:0] pre_data;

  logic [7:0] mem   [128];
  logic [7:0] s_mem [128];
  logic [7:0] ref_mem [128];

  int tests = 0;
  int fails = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  mem_swap_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .addr_a(addr_a), .addr_b(addr_b),
    .data_r(data_r), .address_r(address_r), .address_w(address_w),
    .we(we), .data_w(data_w), .busy(busy), .done(done),
    .swap_count(swap_count)
  );

  mem_swap_ctrl #(.COUNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .addr_a(addr_a), .addr_b(addr_b),
    .data_r(s_data_r), .address_r(s_address_r), .address_w(s_address_w),
    .we(s_we), .data_w(s_data_w), .busy(s_busy), .done(s_done),
    .swap_count(s_swap_count)
  );

  // register-file models: combinational read, write on rising edge
  assign data_r   = mem[address_r];
  assign s_data_r = s_mem[s_address_r];

  always @(posedge clk) begin
    if (we) mem[address_w] <= data_w;
    else if (pre_we) mem[pre_addr] <= pre_data;
    if (s_we) s_mem[s_address_w] <= s_data_w;
    else if (pre_we) s_mem[pre_addr] <= pre_data;
  end

  typedef struct {
    logic [6:0]  a;
    logic [6:0]  b;
    logic        load;
    logic [7:0]  init_a;
    logic [7:0]  init_b;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [15:0] exp_we_mask;
    logic [15:0] exp_done_mask;
    logic [15:0] exp_count;
    logic [1:0]  exp_sat;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_mem(input string name);
    int nmis = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) nmis++;
    check(name, nmis, 0);
  endtask

  // Drives one request, samples each following cycle and checks the write
  // traffic against the pre-swap reference contents. Returns which cycles
  // (relative to the start cycle) showed we and done.
  task automatic run_swap(input logic [6:0] a, input logic [6:0] b, input bit noise,
                          output logic [15:0] we_mask, output logic [15:0] done_mask);
    logic [7:0] va, vb;
    va = ref_mem[a];
    vb = ref_mem[b];
    we_mask = '0;
    done_mask = '0;
    @(negedge clk);
    start = 1'b1; addr_a = a; addr_b = b;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start  = noise && (cyc == 2 || cyc == 5);
      addr_a = 7'd1;
      addr_b = 7'd2;
      if (we)   we_mask[cyc] = 1'b1;
      if (done) done_mask[cyc] = 1'b1;
      if (cyc == 1) begin
        check("busy_rd_a", busy, 1);
        check("address_r_rd_a", address_r, a);
      end
      if (cyc == 2) check("address_r_rd_b", address_r, b);
      if (we && cyc == 3) begin
        check("address_w_wr_a", address_w, a);
        check("data_w_wr_a", data_w, vb);
      end
      if (we && cyc == 4) begin
        check("address_w_wr_b", address_w, b);
        check("data_w_wr_b", data_w, va);
      end
    end
    // reference swap
    ref_mem[a] = vb;
    ref_mem[b] = va;
    if (exp_count < 65535) exp_count++;
  endtask

  initial begin
    logic [15:0] wm, dm;
    logic [6:0]  ra_, rb_;
    bit          any_done;

    vecs[0] = '{7'd3,  7'd5,   1'b1, 8'h11, 8'h22, 8'h22, 8'h11, 16'h0018, 16'h0020, 16'd1, 2'd1};
    vecs[1] = '{7'd0,  7'd127, 1'b1, 8'hA5, 8'h5A, 8'h5A, 8'hA5, 16'h0018, 16'h0020, 16'd2, 2'd2};
    vecs[2] = '{7'd0,  7'd127, 1'b0, 8'h00, 8'h00, 8'hA5, 8'h5A, 16'h0018, 16'h0020, 16'd3, 2'd3};
    vecs[3] = '{7'd9,  7'd9,   1'b1, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 16'h0000, 16'h0008, 16'd4, 2'd3};
    vecs[4] = '{7'd10, 7'd20,  1'b1, 8'h01, 8'h02, 8'h02, 8'h01, 16'h0018, 16'h0020, 16'd5, 2'd3};

    rst = 1'b1; start = 1'b0; addr_a = '0; addr_b = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'($urandom);
      mem[i] = ref_mem[i];
      s_mem[i] = ref_mem[i];
    end
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_we", we, 0);
    check("rst_done", done, 0);
    check("rst_count", swap_count, 0);
    check("rst_address_r", address_r, 0);
    check("rst_address_w", address_w, 0);
    check("rst_data_w", data_w, 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].load) begin
        preload(vecs[v].a, vecs[v].init_a);
        preload(vecs[v].b, vecs[v].init_b);
      end
      run_swap(vecs[v].a, vecs[v].b, 1'b0, wm, dm);
      check("vec_we_cycles", wm, vecs[v].exp_we_mask);
      check("vec_done_cycles", dm, vecs[v].exp_done_mask);
      check("vec_mem_a", mem[vecs[v].a], vecs[v].exp_a);
      check("vec_mem_b", mem[vecs[v].b], vecs[v].exp_b);
      check("vec_count", swap_count, vecs[v].exp_count);
      check("vec_sat_count", s_swap_count, vecs[v].exp_sat);
    end

    for (int n = 0; n < 24; n++) begin
      ra_ = 7'($urandom_range(0, 127));
      rb_ = ($urandom_range(0, 3) == 0) ? ra_ : 7'($urandom_range(0, 127));
      run_swap(ra_, rb_, 1'b0, wm, dm);
      check("rnd_we_cycles", wm, (ra_ == rb_) ? 16'h0000 : 16'h0018);
      check("rnd_done_cycles", dm, (ra_ == rb_) ? 16'h0008 : 16'h0020);
      check_mem("rnd_mem");
      check("rnd_count", swap_count, exp_count);
      check("rnd_sat_count", s_swap_count, 3);
    end

    // start pulses in RD_B and DONE must be dropped
    run_swap(7'd50, 7'd60, 1'b1, wm, dm);
    check("ign_done_cycles", dm, 16'h0020);
    check("ign_mem1", mem[1], ref_mem[1]);
    check("ign_mem2", mem[2], ref_mem[2]);
    check_mem("ign_mem");
    check("ign_count", swap_count, exp_count);

    // reset during RD_B
    @(negedge clk); start = 1'b1; addr_a = 7'd30; addr_b = 7'd40;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rdb_rst_busy", busy, 0);
    check("rdb_rst_we", we, 0);
    check("rdb_rst_done", done, 0);
    any_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || we) any_done = 1'b1;
    end
    check("rdb_rst_no_activity", any_done, 0);
    check_mem("rdb_rst_mem");

    // reset during WR_B: only the WR_A write survives
    @(negedge clk); start = 1'b1; addr_a = 7'd70; addr_b = 7'd80;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wrb_wr_a_we", we, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    ref_mem[70] = ref_mem[80];
    exp_count = 0;
    check("wrb_rst_address_r", address_r, 0);
    check("wrb_rst_address_w", address_w, 0);
    check("wrb_rst_data_w", data_w, 0);
    check("wrb_rst_we", we, 0);
    check("wrb_rst_busy", busy, 0);
    check("wrb_rst_done", done, 0);
    check("wrb_rst_count", swap_count, 0);
    check("wrb_rst_sat_count", s_swap_count, 0);
    check_mem("wrb_rst_mem");

    // resumes normally after reset
    run_swap(7'd70, 7'd80, 1'b0, wm, dm);
    check("post_rst_done", dm, 16'h0020);
    check_mem("post_rst_mem");
    check("post_rst_count", swap_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
